// File: rtl/soc_noc_packet_arbiter.sv
// soc_noc_packet_arbiter
// Packet-level round-robin arbiter that shares one NoC output channel between
// INPUTS flit-stream requesters. A packet is forwarded combinationally from
// its requester to the channel with no buffering. Once a multi-flit packet has
// started, its requester keeps the channel until its last flit, so packets
// never interleave.
//
// Handshake: a flit moves on a port in every cycle where valid and ready are
// both high at the rising clock edge. A valid flit must be held stable by its
// source until it is accepted. out_valid and out_flit/out_last never depend on
// out_ready. in_ready of the selected requester follows out_ready directly,
// and every other in_ready is low.
module soc_noc_packet_arbiter #(
    parameter int FLIT_WIDTH  = 32,
    parameter int INPUTS      = 2,
    parameter int MAX_PKT_LEN = 12
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [INPUTS*FLIT_WIDTH-1:0] in_flit,
    input  logic [INPUTS-1:0]            in_last,
    input  logic [INPUTS-1:0]            in_valid,
    output logic [INPUTS-1:0]            in_ready,
    output logic [FLIT_WIDTH-1:0]        out_flit,
    output logic                         out_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [INPUTS-1:0]            grant,
    output logic                         err_overlong
);

    // Width of a requester index and of the per-packet flit counter.
    localparam int PTR_W = (INPUTS > 1) ? $clog2(INPUTS) : 1;
    localparam int CNT_W = (MAX_PKT_LEN > 1) ? $clog2(MAX_PKT_LEN + 1) : 1;

    // Arbiter states. IDLE arbitrates a fresh packet every cycle; LOCKED
    // forwards only the current owner until its last flit.
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]       state_q;
    logic [PTR_W-1:0] rr_ptr_q;
    logic [PTR_W-1:0] owner_q;
    logic [CNT_W-1:0] flit_cnt_q;
    logic             err_q;

    logic [PTR_W-1:0]      winner;
    logic                  found;
    logic [PTR_W-1:0]      sel;
    logic                  sel_active;
    logic [FLIT_WIDTH-1:0] sel_flit;
    logic                  sel_valid;
    logic                  sel_last;
    logic                  xfer;
    logic                  flit_is_max;

    // Next requester index after p, wrapping at INPUTS (not a power of two
    // in general, so a plain increment is not enough).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (int'(p) >= INPUTS - 1) begin
            r = '0;
        end else begin
            r = p + 1'b1;
        end
        return r;
    endfunction

    // Cyclic priority search starting at rr_ptr. The loop walks the offsets
    // from farthest to nearest so the nearest valid requester is the last
    // one written, i.e. the one that wins.
    always_comb begin
        int               cand;
        logic [PTR_W-1:0] cidx;
        winner = '0;
        found  = 1'b0;
        cand   = 0;
        cidx   = '0;
        for (int k = INPUTS - 1; k >= 0; k--) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= INPUTS) begin
                cand = cand - INPUTS;
            end
            cidx = cand[PTR_W-1:0];
            if (in_valid[cidx]) begin
                winner = cidx;
                found  = 1'b1;
            end
        end
    end

    // Pick the requester whose flit is presented: the owner while LOCKED,
    // otherwise the current round-robin winner (if any input is valid).
    always_comb begin
        if (state_q == ST_LOCKED) begin
            sel        = owner_q;
            sel_active = 1'b1;
        end else begin
            sel        = winner;
            sel_active = found;
        end
        sel_flit  = in_flit[int'(sel)*FLIT_WIDTH +: FLIT_WIDTH];
        sel_valid = sel_active & in_valid[sel];
        sel_last  = in_last[sel];
    end

    // Drive the channel and the handshakes. Everything is forced quiet
    // while rst is high so nothing leaks downstream during reset.
    always_comb begin
        out_valid = 1'b0;
        out_flit  = '0;
        out_last  = 1'b0;
        in_ready  = '0;
        grant     = '0;
        if (!rst) begin
            out_valid = sel_valid;
            out_flit  = sel_flit;
            out_last  = sel_last;
            if (sel_active) begin
                in_ready[sel] = out_ready;
            end
            if (state_q == ST_LOCKED) begin
                grant[owner_q] = 1'b1;
            end
        end
    end

    // A flit crosses the arbiter this cycle.
    assign xfer = out_valid & out_ready;

    // The flit now moving is number flit_cnt+1 of its packet; reaching the
    // legal maximum without last=1 means the packet is overlong.
    assign flit_is_max = ((int'(flit_cnt_q) + 1) == MAX_PKT_LEN);

    // Arbitration state, packet ownership, flit counting and the sticky
    // overlong flag. Nothing changes unless a flit actually transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            flit_cnt_q <= '0;
            err_q      <= 1'b0;
        end else if (xfer) begin
            if (flit_is_max && !sel_last) begin
                err_q <= 1'b1;
            end
            if (state_q == ST_IDLE) begin
                if (sel_last) begin
                    // Single-flit packet: never lock, just move the pointer.
                    rr_ptr_q <= ptr_inc(winner);
                end else begin
                    state_q    <= ST_LOCKED;
                    owner_q    <= winner;
                    flit_cnt_q <= CNT_W'(1);
                end
            end else begin
                if (sel_last) begin
                    state_q    <= ST_IDLE;
                    rr_ptr_q   <= ptr_inc(owner_q);
                    flit_cnt_q <= '0;
                end else if (int'(flit_cnt_q) < MAX_PKT_LEN) begin
                    flit_cnt_q <= flit_cnt_q + 1'b1;
                end
            end
        end
    end

    assign err_overlong = err_q;

endmodule

// File: tb/tb_soc_noc_packet_arbiter.sv
// tb_soc_noc_packet_arbiter
// Directed bench for the packet arbiter, built with INPUTS=3 and
// MAX_PKT_LEN=4 so that round-robin wrap over a non-power-of-two count and
// the overlong flag are both reachable with short packets. Inputs change 1
// time unit after a rising edge; combinational outputs are checked 1 unit
// later, and a negedge monitor checks every forwarded flit against an
// expected queue.
module tb_soc_noc_packet_arbiter;

    localparam int FW = 32;
    localparam int NI = 3;
    localparam int ML = 4;

    logic              clk;
    logic              rst;
    logic [NI*FW-1:0]  in_flit;
    logic [NI-1:0]     in_last;
    logic [NI-1:0]     in_valid;
    logic [NI-1:0]     in_ready;
    logic [FW-1:0]     out_flit;
    logic              out_last;
    logic              out_valid;
    logic              out_ready;
    logic [NI-1:0]     grant;
    logic              err_overlong;

    logic [FW-1:0]     flit_d [NI];
    logic [FW-1:0]     exp_q [$];
    int                checks;
    int                errors;

    assign in_flit = {flit_d[2], flit_d[1], flit_d[0]};

    soc_noc_packet_arbiter #(
        .FLIT_WIDTH  (FW),
        .INPUTS      (NI),
        .MAX_PKT_LEN (ML)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_flit      (in_flit),
        .in_last      (in_last),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .out_flit     (out_flit),
        .out_last     (out_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .grant        (grant),
        .err_overlong (err_overlong)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one requester.
    task automatic set_in(input int i, input logic v, input logic [FW-1:0] f, input logic l);
        in_valid[i] = v;
        flit_d[i]   = f;
        in_last[i]  = l;
    endtask

    task automatic idle_all();
        for (int i = 0; i < NI; i++) set_in(i, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_all();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // Check the combinational outputs of the current cycle.
    task automatic outs(input string tag, input logic v, input logic [FW-1:0] f,
                        input logic l, input logic [NI-1:0] rdy, input logic [NI-1:0] g);
        #1;
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        if (v) begin
            chk({tag, ".flit"}, out_flit, f);
            chk({tag, ".last"}, 32'(out_last), 32'(l));
        end
        chk({tag, ".ready"}, 32'(in_ready), 32'(rdy));
        chk({tag, ".grant"}, 32'(grant), 32'(g));
    endtask

    // Scoreboard: every accepted output flit must be the next expected one.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL sb_extra observed=%h expected=none", out_flit);
            end else begin
                logic [FW-1:0] e;
                e = exp_q.pop_front();
                assert (out_flit === e) else begin
                    errors++;
                    $error("FAIL sb_order observed=%h expected=%h", out_flit, e);
                end
            end
        end
    end

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        out_ready = 1'b1;
        idle_all();

        // Reset: all requesters valid, outputs must stay quiet.
        #1;
        set_in(0, 1'b1, 32'h11, 1'b0);
        set_in(1, 1'b1, 32'h22, 1'b1);
        set_in(2, 1'b1, 32'h33, 1'b0);
        cyc();
        outs("rst_quiet", 1'b0, '0, 1'b0, 3'b000, 3'b000);
        chk("rst_flit", out_flit, 32'h0);
        chk("rst_last", 32'(out_last), 32'h0);
        chk("rst_err", 32'(err_overlong), 32'h0);
        idle_all();
        cyc();
        rst = 1'b0;

        // 1: three-flit packet on input 0.
        set_in(0, 1'b1, 32'hA, 1'b0); exp_q.push_back(32'hA);
        outs("t1_f1", 1'b1, 32'hA, 1'b0, 3'b001, 3'b000);
        cyc();
        set_in(0, 1'b1, 32'hB, 1'b0); exp_q.push_back(32'hB);
        outs("t1_f2", 1'b1, 32'hB, 1'b0, 3'b001, 3'b001);
        cyc();
        set_in(0, 1'b1, 32'hC, 1'b1); exp_q.push_back(32'hC);
        outs("t1_f3", 1'b1, 32'hC, 1'b1, 3'b001, 3'b001);
        cyc();
        idle_all();
        outs("t1_done", 1'b0, '0, 1'b0, 3'b000, 3'b000);
        chk("t1_err", 32'(err_overlong), 32'h0);

        // 2: both inputs request right after reset; input 0 first.
        do_reset();
        set_in(0, 1'b1, 32'h10, 1'b0); exp_q.push_back(32'h10);
        set_in(1, 1'b1, 32'h20, 1'b0);
        outs("t2_a0", 1'b1, 32'h10, 1'b0, 3'b001, 3'b000);
        cyc();
        set_in(0, 1'b1, 32'h11, 1'b1); exp_q.push_back(32'h11);
        outs("t2_a1", 1'b1, 32'h11, 1'b1, 3'b001, 3'b001);
        cyc();
        set_in(0, 1'b0, '0, 1'b0); exp_q.push_back(32'h20);
        outs("t2_b0", 1'b1, 32'h20, 1'b0, 3'b010, 3'b000);
        cyc();
        set_in(1, 1'b1, 32'h21, 1'b1); exp_q.push_back(32'h21);
        outs("t2_b1", 1'b1, 32'h21, 1'b1, 3'b010, 3'b010);
        cyc();
        idle_all();

        // 3: continuous single-flit packets from all three inputs.
        do_reset();
        for (int i = 0; i < NI; i++) set_in(i, 1'b1, 32'(32'h30 + i), 1'b1);
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(32'(32'h30 + (k % 3)));
            outs($sformatf("t3_rr%0d", k), 1'b1, 32'(32'h30 + (k % 3)), 1'b1,
                 3'(1 << (k % 3)), 3'b000);
            cyc();
        end
        // Move rr_ptr to 2 with a lone packet from input 1.
        idle_all();
        set_in(1, 1'b1, 32'h31, 1'b1); exp_q.push_back(32'h31);
        outs("t3_ptr", 1'b1, 32'h31, 1'b1, 3'b010, 3'b000);
        cyc();
        idle_all();
        set_in(0, 1'b1, 32'h30, 1'b1);
        set_in(2, 1'b1, 32'h32, 1'b1);
        exp_q.push_back(32'h32);
        outs("t3_w2", 1'b1, 32'h32, 1'b1, 3'b100, 3'b000);
        cyc();
        set_in(2, 1'b0, '0, 1'b0);
        exp_q.push_back(32'h30);
        outs("t3_w0", 1'b1, 32'h30, 1'b1, 3'b001, 3'b000);
        cyc();
        idle_all();

        // 4: stall for 4 cycles after flit 2 of a 5-flit packet.
        do_reset();
        set_in(1, 1'b1, 32'h50, 1'b1);
        set_in(0, 1'b1, 32'h40, 1'b0); exp_q.push_back(32'h40);
        outs("t4_f1", 1'b1, 32'h40, 1'b0, 3'b001, 3'b000);
        cyc();
        set_in(0, 1'b1, 32'h41, 1'b0); exp_q.push_back(32'h41);
        outs("t4_f2", 1'b1, 32'h41, 1'b0, 3'b001, 3'b001);
        cyc();
        set_in(0, 1'b1, 32'h42, 1'b0);
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            outs($sformatf("t4_stall%0d", k), 1'b1, 32'h42, 1'b0, 3'b000, 3'b001);
            cyc();
        end
        out_ready = 1'b1;
        exp_q.push_back(32'h42);
        outs("t4_f3", 1'b1, 32'h42, 1'b0, 3'b001, 3'b001);
        cyc();
        set_in(0, 1'b1, 32'h43, 1'b0); exp_q.push_back(32'h43);
        outs("t4_f4", 1'b1, 32'h43, 1'b0, 3'b001, 3'b001);
        cyc();
        set_in(0, 1'b1, 32'h44, 1'b1); exp_q.push_back(32'h44);
        outs("t4_f5", 1'b1, 32'h44, 1'b1, 3'b001, 3'b001);
        cyc();
        set_in(0, 1'b0, '0, 1'b0); exp_q.push_back(32'h50);
        outs("t4_other", 1'b1, 32'h50, 1'b1, 3'b010, 3'b000);
        chk("t4_err", 32'(err_overlong), 32'h1);
        cyc();
        idle_all();

        // 5: 6-flit packet against MAX_PKT_LEN=4 on input 2.
        do_reset();
        for (int j = 0; j < 6; j++) begin
            set_in(2, 1'b1, 32'(32'h60 + j), (j == 5));
            exp_q.push_back(32'(32'h60 + j));
            outs($sformatf("t5_f%0d", j + 1), 1'b1, 32'(32'h60 + j), (j == 5),
                 3'b100, (j == 0) ? 3'b000 : 3'b100);
            chk($sformatf("t5_err%0d", j + 1), 32'(err_overlong), (j >= 4) ? 32'h1 : 32'h0);
            cyc();
        end
        idle_all();
        chk("t5_err_after", 32'(err_overlong), 32'h1);
        set_in(0, 1'b1, 32'h70, 1'b1); exp_q.push_back(32'h70);
        outs("t5_next", 1'b1, 32'h70, 1'b1, 3'b001, 3'b000);
        cyc();
        idle_all();
        chk("t5_err_sticky", 32'(err_overlong), 32'h1);

        // 6: reset after 2 of 5 flits, then input 1 is served at once.
        set_in(0, 1'b1, 32'h80, 1'b0); exp_q.push_back(32'h80);
        outs("t6_f1", 1'b1, 32'h80, 1'b0, 3'b001, 3'b000);
        cyc();
        set_in(0, 1'b1, 32'h81, 1'b0); exp_q.push_back(32'h81);
        outs("t6_f2", 1'b1, 32'h81, 1'b0, 3'b001, 3'b001);
        cyc();
        set_in(0, 1'b1, 32'h82, 1'b0);
        rst = 1'b1;
        outs("t6_in_rst", 1'b0, '0, 1'b0, 3'b000, 3'b000);
        chk("t6_rst_flit", out_flit, 32'h0);
        cyc();
        chk("t6_err_clr", 32'(err_overlong), 32'h0);
        chk("t6_grant_clr", 32'(grant), 32'h0);
        chk("t6_valid_clr", 32'(out_valid), 32'h0);
        rst = 1'b0;
        set_in(0, 1'b0, '0, 1'b0);
        set_in(1, 1'b1, 32'h90, 1'b1); exp_q.push_back(32'h90);
        outs("t6_new", 1'b1, 32'h90, 1'b1, 3'b010, 3'b000);
        cyc();
        idle_all();
        cyc();

        chk("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
